// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: 1 Hz tick generator and set-mode sequencer for a 24-hour
// BCD time-of-day counter. In SET states the user edits a private copy of
// the time and commits it to the counter with a one-cycle parallel load.
module clock_set_ctrl #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int BLINK_HALF    = 25000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_hour1,
    input  logic [3:0] cur_hour0,
    input  logic [3:0] cur_min1,
    input  logic [3:0] cur_min0,
    input  logic [3:0] cur_sec1,
    input  logic [3:0] cur_sec0,
    output logic       tick,
    output logic       load,
    output logic [3:0] ld_hour1,
    output logic [3:0] ld_hour0,
    output logic [3:0] ld_min1,
    output logic [3:0] ld_min0,
    output logic [3:0] ld_sec1,
    output logic [3:0] ld_sec0,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int BW = $clog2(BLINK_HALF + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2,
        ST_SET_S = 2'd3
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_presc;
    logic            r_tick;
    logic            r_load;
    logic [BW-1:0]   r_blink_cnt;
    logic            r_blink;
    logic [7:0]      r_ld_hour;
    logic [7:0]      r_ld_min;
    logic [7:0]      r_ld_sec;

    // Hour field: 23 wraps to 00, otherwise BCD increment with digit carry.
    function automatic logic [7:0] inc_hour(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Minute/second field: 59 wraps to 00, otherwise BCD increment.
    function automatic logic [7:0] inc_sixty(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h59) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Set-mode FSM: snapshot on entry, field edits, load strobe on exit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= ST_RUN;
            r_load    <= 1'b0;
            r_ld_hour <= 8'h00;
            r_ld_min  <= 8'h00;
            r_ld_sec  <= 8'h00;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (btn_mode) begin
                        r_state   <= ST_SET_H;
                        r_ld_hour <= {cur_hour1, cur_hour0};
                        r_ld_min  <= {cur_min1, cur_min0};
                        r_ld_sec  <= {cur_sec1, cur_sec0};
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_SET_H: begin
                    if (btn_mode) begin
                        r_state <= ST_SET_M;
                    end else if (btn_inc) begin
                        r_ld_hour <= inc_hour(r_ld_hour);
                    end else begin
                        r_state <= ST_SET_H;
                    end
                end
                ST_SET_M: begin
                    if (btn_mode) begin
                        r_state <= ST_SET_S;
                    end else if (btn_inc) begin
                        r_ld_min <= inc_sixty(r_ld_min);
                    end else begin
                        r_state <= ST_SET_M;
                    end
                end
                ST_SET_S: begin
                    if (btn_mode) begin
                        r_state <= ST_RUN;
                        r_load  <= 1'b1;
                    end else if (btn_inc) begin
                        r_ld_sec <= inc_sixty(r_ld_sec);
                    end else begin
                        r_state <= ST_SET_S;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Prescaler: free-runs only while in RUN with no mode press, so both
    // entering set mode and committing a load restart the second at zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else if ((r_state == ST_RUN) && !btn_mode) begin
            if (r_presc == PW'(TICKS_PER_SEC - 1)) begin
                r_presc <= '0;
                r_tick  <= 1'b1;
            end else begin
                r_presc <= r_presc + PW'(1);
                r_tick  <= 1'b0;
            end
        end else begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end
    end

    // Blink phase: restarts visible on every SET-state entry, cleared in RUN.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (btn_mode) begin
            r_blink_cnt <= '0;
            r_blink     <= (r_state != ST_SET_S);
        end else if (r_state == ST_RUN) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
            r_blink     <= r_blink;
        end
    end

    assign tick     = r_tick;
    assign load     = r_load;
    assign mode     = r_state;
    assign blink    = r_blink;
    assign ld_hour1 = r_ld_hour[7:4];
    assign ld_hour0 = r_ld_hour[3:0];
    assign ld_min1  = r_ld_min[7:4];
    assign ld_min0  = r_ld_min[3:0];
    assign ld_sec1  = r_ld_sec[7:4];
    assign ld_sec0  = r_ld_sec[3:0];

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: stimulus pushes hand-computed
// expectations per cycle, a monitor pops and compares after each edge.
module tb_clock_set_ctrl;

    logic       clk;
    logic       rstn;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] cur_hour1, cur_hour0, cur_min1, cur_min0, cur_sec1, cur_sec0;
    logic       tick, load, blink;
    logic [1:0] mode;
    logic [3:0] ld_hour1, ld_hour0, ld_min1, ld_min0, ld_sec1, ld_sec0;

    typedef struct {
        int          cyc;
        logic [1:0]  m;
        logic        t;
        logic        l;
        int          b;
        logic [23:0] ld;
        logic        cld;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   checks;
    int   errors;

    clock_set_ctrl #(.TICKS_PER_SEC(4), .BLINK_HALF(2)) dut (
        .clk(clk), .rstn(rstn), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_hour1(cur_hour1), .cur_hour0(cur_hour0),
        .cur_min1(cur_min1), .cur_min0(cur_min0),
        .cur_sec1(cur_sec1), .cur_sec0(cur_sec0),
        .tick(tick), .load(load),
        .ld_hour1(ld_hour1), .ld_hour0(ld_hour0),
        .ld_min1(ld_min1), .ld_min0(ld_min0),
        .ld_sec1(ld_sec1), .ld_sec0(ld_sec0),
        .mode(mode), .blink(blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp_v);
        checks = checks + 1;
        if (act !== exp_v) begin
            errors = errors + 1;
            $display("FAIL cyc=%0d %s actual=%h expected=%h", cyc, name, act, exp_v);
        end
    endtask

    // Monitor: after each edge, compare outputs with the expectation for that cycle.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc < cyc) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL missed expectation for cycle %0d at cycle %0d", e.cyc, cyc);
                end else begin
                    chk("mode", {22'd0, mode}, {22'd0, e.m});
                    chk("tick", {23'd0, tick}, {23'd0, e.t});
                    chk("load", {23'd0, load}, {23'd0, e.l});
                    if (e.b >= 0) chk("blink", {23'd0, blink}, 24'(e.b));
                    if (e.cld) chk("ld", {ld_hour1, ld_hour0, ld_min1, ld_min0, ld_sec1, ld_sec0}, e.ld);
                end
            end
        end
    end

    task automatic set_cur(input logic [23:0] t);
        {cur_hour1, cur_hour0, cur_min1, cur_min0, cur_sec1, cur_sec0} = t;
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic m, input logic i, input logic [1:0] em, input logic et,
                        input logic el, input int eb, input logic [23:0] eld, input logic cld);
        exp_t e;
        btn_mode = m;
        btn_inc  = i;
        e.cyc = cyc + 1;
        e.m = em; e.t = et; e.l = el; e.b = eb; e.ld = eld; e.cld = cld;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        set_cur(24'h000000);

        // Reset state
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 24'h000000, 1'b1);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 24'h000000, 1'b1);
        rstn = 1'b1;
        // Free-running ticks on cycles 4, 8, 12
        for (int k = 1; k <= 12; k++)
            step(1'b0, 1'b0, 2'd0, (k % 4) == 0, 1'b0, 0, 24'h000000, 1'b1);

        // Full edit from 23:59:59 to 00:01:00
        set_cur(24'h235959);
        step(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1, 24'h235959, 1'b1);
        step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1, 24'h005959, 1'b1);
        step(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1, 24'h005959, 1'b1);
        step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1, 24'h000059, 1'b1);
        step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 0, 24'h000159, 1'b1);
        step(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1, 24'h000159, 1'b1);
        step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1, 24'h000100, 1'b1);
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 0, 24'h000100, 1'b1);
        for (int k = 1; k <= 4; k++)
            step(1'b0, 1'b0, 2'd0, k == 4, 1'b0, 0, 24'h000100, 1'b1);

        // Digit0 carry: 09 -> 10 hours, 19 -> 20 minutes
        set_cur(24'h091958);
        step(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1, 24'h091958, 1'b1);
        step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1, 24'h101958, 1'b1);
        step(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1, 24'h101958, 1'b1);
        step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1, 24'h102058, 1'b1);
        step(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1, 24'h102058, 1'b1);
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 0, 24'h102058, 1'b1);
        for (int k = 1; k <= 3; k++)
            step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 24'h102058, 1'b1);

        // Mode press on the would-be wrap cycle: no tick, fresh snapshot
        set_cur(24'h123456);
        step(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1, 24'h123456, 1'b1);
        step(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1, 24'h123456, 1'b1);
        // Mode and inc together in SET_M: mode wins, minutes unchanged
        step(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1, 24'h123456, 1'b1);
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 0, 24'h123456, 1'b1);
        // Inc in RUN ignored; tick 4 cycles after load
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 0, 24'h123456, 1'b1);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 24'h123456, 1'b1);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 24'h123456, 1'b1);
        step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 0, 24'h123456, 1'b1);

        // Reset mid-edit discards edits with no load
        step(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1, 24'h123456, 1'b1);
        step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1, 24'h133456, 1'b1);
        step(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1, 24'h133456, 1'b1);
        step(1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1, 24'h133456, 1'b1);
        step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, -1, 24'h133457, 1'b1);
        rstn = 1'b0;
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 24'h000000, 1'b1);
        rstn = 1'b1;
        for (int k = 1; k <= 4; k++)
            step(1'b0, 1'b0, 2'd0, k == 4, 1'b0, 0, 24'h000000, 1'b1);

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
